// File: rtl/mips_avalon_slave_mem_if.sv
// Avalon-MM bus bundle between a CPU-side master (cache write buffer or
// read-miss path) and the memory responder.
interface mips_avalon_slave_mem_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_avalon_slave_mem.sv
// Word-addressed Avalon-MM RAM responder. Every transfer is stretched by a
// fixed or LFSR-derived number of waitrequest cycles. Protocol and address
// violations raise sticky flags, and accepted transfers are counted.
module mips_avalon_slave_mem #(
  parameter logic [31:0] BASE_ADDR    = 32'hBFC00000,
  parameter int          DEPTH_BITS   = 10,
  parameter int          STALL_MODE   = 0,
  parameter int          STALL_CYCLES = 1,
  parameter int          STALL_BITS   = 2,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic                      clk,
  input  logic                      rst,
  mips_avalon_slave_mem_if.slave    bus,
  output logic                      protocol_err,
  output logic                      addr_err,
  output logic [15:0]               txn_count
);

  localparam int WORDS = 1 << DEPTH_BITS;
  localparam int CNT_W = 16;

  typedef enum logic {S_IDLE, S_STALL} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic [31:0]        readdata_q, readdata_d;
  logic               protocol_err_q, protocol_err_d;
  logic               addr_err_q, addr_err_d;
  logic [15:0]        txn_count_q, txn_count_d;

  logic [31:0] mem [WORDS];

  logic                  req;
  logic                  both;
  logic [CNT_W-1:0]      stall_len;
  logic [29:0]           word_off;
  logic                  in_range;
  logic                  misaligned;
  logic [DEPTH_BITS-1:0] idx;
  logic                  commit;
  logic                  wait_req;
  logic [7:0]            lfsr_next;
  logic                  mem_we;

  // Request decode, address translation and stall length selection.
  always_comb begin
    req        = bus.read ^ bus.write;
    both       = bus.read & bus.write;
    // Offset computed on word addresses so the byte-lane bits only feed the
    // alignment check.
    word_off   = bus.address[31:2] - BASE_ADDR[31:2];
    misaligned = (bus.address[1:0] != 2'b00);
    in_range   = (bus.address >= BASE_ADDR) && (word_off[29:DEPTH_BITS] == '0);
    idx        = word_off[DEPTH_BITS-1:0];
    lfsr_next  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    if (STALL_MODE != 0) stall_len = CNT_W'(lfsr_q[STALL_BITS-1:0]);
    else                 stall_len = CNT_W'(STALL_CYCLES);
  end

  // Next-state logic: stall sequencing, commit detection and status updates.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d        = state_q;
    cnt_d          = cnt_q;
    lfsr_d         = lfsr_q;
    readdata_d     = readdata_q;
    protocol_err_d = protocol_err_q;
    addr_err_d     = addr_err_q;
    txn_count_d    = txn_count_q;
    wait_req       = 1'b0;
    commit         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (both) begin
          protocol_err_d = 1'b1;
        end else if (req) begin
          if (stall_len == '0) begin
            commit = 1'b1;
          end else begin
            wait_req = 1'b1;
            cnt_d    = stall_len - 1'b1;
            state_d  = S_STALL;
          end
        end
      end
      S_STALL: begin
        if (!req) begin
          // Master withdrew (or doubled up) its request before acceptance.
          protocol_err_d = 1'b1;
          state_d        = S_IDLE;
        end else if (cnt_q != '0) begin
          wait_req = 1'b1;
          cnt_d    = cnt_q - 1'b1;
        end else begin
          commit  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      txn_count_d = txn_count_q + 16'd1;
      if (STALL_MODE != 0) lfsr_d = lfsr_next;
      if (misaligned || !in_range) addr_err_d = 1'b1;
      if (bus.read) readdata_d = in_range ? mem[idx] : 32'h0;
    end
  end

  // A write that lands while reset is asserted must not touch the array.
  assign mem_we = commit && bus.write && in_range && rst;

  assign bus.waitrequest = wait_req;
  assign bus.readdata    = readdata_q;
  assign protocol_err    = protocol_err_q;
  assign addr_err        = addr_err_q;
  assign txn_count       = txn_count_q;

  // Control and status registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      lfsr_q         <= LFSR_SEED;
      readdata_q     <= 32'h0;
      protocol_err_q <= 1'b0;
      addr_err_q     <= 1'b0;
      txn_count_q    <= 16'h0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      lfsr_q         <= lfsr_d;
      readdata_q     <= readdata_d;
      protocol_err_q <= protocol_err_d;
      addr_err_q     <= addr_err_d;
      txn_count_q    <= txn_count_d;
    end
  end

  // Byte-lane write port of the storage array.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; contents are undefined until written,
    // which keeps it mappable onto RAM macros.
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.byteenable[i]) mem[idx][8*i +: 8] <= bus.writedata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mips_avalon_slave_mem.sv
// Self-checking bench: three responders (fixed 2-cycle stall, zero stall,
// LFSR-random stall) driven through a shared set of stimulus arrays.
module tb_mips_avalon_slave_mem;

  localparam logic [31:0] BASE = 32'hBFC00000;
  localparam int          DB   = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        m_rst   [3];
  logic [31:0] m_addr  [3];
  logic        m_rd    [3];
  logic        m_wr    [3];
  logic [31:0] m_wd    [3];
  logic [3:0]  m_be    [3];
  logic        s_wait  [3];
  logic [31:0] s_rdata [3];
  logic        s_perr  [3];
  logic        s_aerr  [3];
  logic [15:0] s_txn   [3];

  mips_avalon_slave_mem_if if_fix ();
  mips_avalon_slave_mem_if if_zero ();
  mips_avalon_slave_mem_if if_rnd ();

  assign if_fix.address     = m_addr[0];
  assign if_fix.read        = m_rd[0];
  assign if_fix.write       = m_wr[0];
  assign if_fix.writedata   = m_wd[0];
  assign if_fix.byteenable  = m_be[0];
  assign if_zero.address    = m_addr[1];
  assign if_zero.read       = m_rd[1];
  assign if_zero.write      = m_wr[1];
  assign if_zero.writedata  = m_wd[1];
  assign if_zero.byteenable = m_be[1];
  assign if_rnd.address     = m_addr[2];
  assign if_rnd.read        = m_rd[2];
  assign if_rnd.write       = m_wr[2];
  assign if_rnd.writedata   = m_wd[2];
  assign if_rnd.byteenable  = m_be[2];

  assign s_wait[0]  = if_fix.waitrequest;
  assign s_rdata[0] = if_fix.readdata;
  assign s_wait[1]  = if_zero.waitrequest;
  assign s_rdata[1] = if_zero.readdata;
  assign s_wait[2]  = if_rnd.waitrequest;
  assign s_rdata[2] = if_rnd.readdata;

  mips_avalon_slave_mem #(.BASE_ADDR(BASE), .DEPTH_BITS(DB), .STALL_MODE(0),
                          .STALL_CYCLES(2)) u_fix (
    .clk(clk), .rst(m_rst[0]), .bus(if_fix),
    .protocol_err(s_perr[0]), .addr_err(s_aerr[0]), .txn_count(s_txn[0]));

  mips_avalon_slave_mem #(.BASE_ADDR(BASE), .DEPTH_BITS(DB), .STALL_MODE(0),
                          .STALL_CYCLES(0)) u_zero (
    .clk(clk), .rst(m_rst[1]), .bus(if_zero),
    .protocol_err(s_perr[1]), .addr_err(s_aerr[1]), .txn_count(s_txn[1]));

  mips_avalon_slave_mem #(.BASE_ADDR(BASE), .DEPTH_BITS(DB), .STALL_MODE(1),
                          .STALL_BITS(2), .LFSR_SEED(8'hA5)) u_rnd (
    .clk(clk), .rst(m_rst[2]), .bus(if_rnd),
    .protocol_err(s_perr[2]), .addr_err(s_aerr[2]), .txn_count(s_txn[2]));

  // Reference memory contents keyed by instance and word index.
  logic [31:0] model_mem [int];
  // Expected readdata, pushed when a read is issued, popped when it returns.
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a >= BASE) && ((off >> 2) < (32'd1 << DB));
  endfunction

  function automatic int mkey(input int d, input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) >> 2;
    return d * 4096 + int'(off);
  endfunction

  function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
    if (!addr_ok(a)) return 32'h0;
    if (!model_mem.exists(mkey(d, a))) return 32'hxxxxxxxx;
    return model_mem[mkey(d, a)];
  endfunction

  function automatic void model_write(input int d, input logic [31:0] a,
                                      input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] w;
    if (!addr_ok(a)) return;
    w = model_mem.exists(mkey(d, a)) ? model_mem[mkey(d, a)] : 32'h0;
    for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
    model_mem[mkey(d, a)] = w;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    // x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB.
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // One complete transfer: drive, count stall cycles, wait for acceptance,
  // then release the bus and compare stall length and read data.
  task automatic xfer(input int d, input bit is_wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be,
                      input int exp_stall, input string tag);
    int stall;
    bit done;
    @(negedge clk);
    m_addr[d] = a; m_wd[d] = wd; m_be[d] = be;
    m_rd[d] = !is_wr; m_wr[d] = is_wr;
    if (is_wr) model_write(d, a, wd, be);
    else       exp_q.push_back(model_read(d, a));
    stall = 0;
    done  = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      #1;
      if (s_wait[d]) begin
        stall++;
        @(negedge clk);
      end else begin
        @(posedge clk);
        done = 1'b1;
      end
    end
    @(negedge clk);
    m_rd[d] = 1'b0; m_wr[d] = 1'b0;
    check({tag, " accepted"}, 32'(done), 32'd1);
    if (exp_stall >= 0) check({tag, " stall"}, 32'(stall), 32'(exp_stall));
    if (!is_wr) check({tag, " readdata"}, s_rdata[d], exp_q.pop_front());
  endtask

  initial begin
    logic [7:0] lfsr_m;
    for (int d = 0; d < 3; d++) begin
      m_rst[d] = 1'b0; m_addr[d] = BASE; m_rd[d] = 1'b0; m_wr[d] = 1'b0;
      m_wd[d] = 32'h0; m_be[d] = 4'h0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) m_rst[d] = 1'b1;
    #1;

    // Reset state of every instance.
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst%0d readdata", d), s_rdata[d], 32'h0);
      check($sformatf("rst%0d txn", d), 32'(s_txn[d]), 32'h0);
      check($sformatf("rst%0d perr", d), 32'(s_perr[d]), 32'h0);
      check($sformatf("rst%0d aerr", d), 32'(s_aerr[d]), 32'h0);
      check($sformatf("rst%0d wait", d), 32'(s_wait[d]), 32'h0);
    end

    // Fixed 2-cycle stalls: full write, read back, partial write.
    xfer(0, 1, BASE,       32'h01234567, 4'hF, 2, "fix wr0");
    xfer(0, 1, BASE + 4,   32'hDEADBEEF, 4'hF, 2, "fix wr1");
    xfer(0, 0, BASE + 4,   32'h0,        4'h0, 2, "fix rd1");
    xfer(0, 1, BASE + 4,   32'h11223344, 4'b0101, 2, "fix pwr1");
    xfer(0, 0, BASE + 4,   32'h0,        4'h0, 2, "fix rd1 merged");
    check("fix merged value", model_read(0, BASE + 4), 32'hDE22BE44);
    check("fix txn after 5", 32'(s_txn[0]), 32'd5);
    check("fix aerr clean", 32'(s_aerr[0]), 32'd0);

    // Write withdrawn mid-stall: flagged, not committed, RAM untouched.
    @(negedge clk);
    m_addr[0] = BASE + 4; m_wd[0] = 32'h0; m_be[0] = 4'hF; m_wr[0] = 1'b1;
    #1 check("drop wait high", 32'(s_wait[0]), 32'd1);
    @(negedge clk);
    m_wr[0] = 1'b0;
    #1 check("drop wait follows req", 32'(s_wait[0]), 32'd0);
    @(negedge clk);
    check("drop perr", 32'(s_perr[0]), 32'd1);
    check("drop txn", 32'(s_txn[0]), 32'd5);
    xfer(0, 0, BASE + 4, 32'h0, 4'h0, 2, "fix rd after drop");

    // Address violations.
    xfer(0, 0, BASE + 2, 32'h0, 4'h0, 2, "misaligned rd");
    check("misaligned aerr", 32'(s_aerr[0]), 32'd1);
    xfer(0, 0, BASE + 4 * (1 << DB), 32'h0, 4'h0, 2, "oor rd");
    xfer(0, 0, BASE + 4, 32'h0, 4'h0, 2, "fix rd nonzero");
    xfer(0, 0, BASE - 4, 32'h0, 4'h0, 2, "below base rd");
    xfer(0, 1, BASE + 4 * (1 << DB), 32'hABCD0123, 4'hF, 2, "oor wr");
    xfer(0, 0, BASE, 32'h0, 4'h0, 2, "word0 after oor wr");
    check("fix txn after 12", 32'(s_txn[0]), 32'd12);

    // Reset asserted while a write is stalled.
    xfer(0, 0, BASE + 4, 32'h0, 4'h0, 2, "fix rd before rst");
    @(negedge clk);
    m_addr[0] = BASE + 4; m_wd[0] = 32'hFFFFFFFF; m_be[0] = 4'hF; m_wr[0] = 1'b1;
    @(negedge clk);
    m_rst[0] = 1'b0;
    #1;
    check("rst mid wait", 32'(s_wait[0]), 32'd1);
    check("rst mid txn", 32'(s_txn[0]), 32'd0);
    check("rst mid readdata", s_rdata[0], 32'h0);
    check("rst mid perr", 32'(s_perr[0]), 32'd0);
    check("rst mid aerr", 32'(s_aerr[0]), 32'd0);
    @(negedge clk);
    m_wr[0] = 1'b0;
    @(negedge clk);
    m_rst[0] = 1'b1;
    xfer(0, 0, BASE + 4, 32'h0, 4'h0, 2, "word after rst");
    check("txn after rst rd", 32'(s_txn[0]), 32'd1);

    // Zero stall: eight back-to-back writes, one per cycle.
    @(negedge clk);
    m_wr[1] = 1'b1; m_be[1] = 4'hF;
    for (int i = 0; i < 8; i++) begin
      m_addr[1] = BASE + 32'(4 * (8 + i));
      m_wd[1]   = 32'hA5000000 + 32'(i * 32'h00010203);
      model_write(1, m_addr[1], m_wd[1], 4'hF);
      #1 check($sformatf("b2b wait %0d", i), 32'(s_wait[1]), 32'd0);
      @(negedge clk);
    end
    m_wr[1] = 1'b0;
    check("b2b txn", 32'(s_txn[1]), 32'd8);
    xfer(1, 0, BASE + 32, 32'h0, 4'h0, 0, "b2b rd first");
    xfer(1, 0, BASE + 60, 32'h0, 4'h0, 0, "b2b rd last");

    // Read and write together: no access, flagged, not counted.
    @(negedge clk);
    m_addr[1] = BASE + 32; m_wd[1] = 32'h0; m_rd[1] = 1'b1; m_wr[1] = 1'b1;
    #1 check("rw both wait", 32'(s_wait[1]), 32'd0);
    @(negedge clk);
    m_rd[1] = 1'b0; m_wr[1] = 1'b0;
    check("rw both perr", 32'(s_perr[1]), 32'd1);
    check("rw both txn", 32'(s_txn[1]), 32'd10);
    xfer(1, 0, BASE + 32, 32'h0, 4'h0, 0, "rw both no write");

    // LFSR-random stalls: sixteen writes then sixteen reads.
    lfsr_m = 8'hA5;
    for (int i = 0; i < 16; i++) begin
      xfer(2, 1, BASE + 32'(4 * i), $urandom, 4'hF, int'(lfsr_m[1:0]),
           $sformatf("rnd wr%0d", i));
      lfsr_m = lfsr_step(lfsr_m);
    end
    for (int i = 0; i < 16; i++) begin
      xfer(2, 0, BASE + 32'(4 * (15 - i)), 32'h0, 4'h0, int'(lfsr_m[1:0]),
           $sformatf("rnd rd%0d", i));
      lfsr_m = lfsr_step(lfsr_m);
    end
    check("rnd txn", 32'(s_txn[2]), 32'd32);
    check("rnd perr", 32'(s_perr[2]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
